// File: rtl/mul_sequencer.sv
// Wraps an external shift-add multiplier: sign handling, zero bypass, watchdog and a held response.
// Response appears BITS+2 cycles after accept (1 for zero bypass); held until rsp_ready, no accept while busy.
module mul_sequencer #(
  parameter int BITS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BITS-1:0]   req_a,
  input  logic [BITS-1:0]   req_b,
  input  logic              req_signed,
  output logic              mul_en,
  output logic [BITS-1:0]   mul_a,
  output logic [BITS-1:0]   mul_b,
  input  logic [2*BITS-1:0] mul_result,
  input  logic              mul_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BITS-1:0]   rsp_hi,
  output logic [BITS-1:0]   rsp_lo,
  output logic              rsp_ovf
);

  localparam int PW     = 2 * BITS;
  localparam int WD_MAX = 2 * BITS + 4;
  localparam int WDW    = $clog2(WD_MAX + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] mag_a_q, mag_a_d;
  logic [BITS-1:0] mag_b_q, mag_b_d;
  logic            neg_q, neg_d;
  logic            sgn_q, sgn_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            ovf_q, ovf_d;

  logic            accept;
  logic            req_zero;
  logic [BITS-1:0] abs_a;
  logic [BITS-1:0] abs_b;
  logic [PW-1:0]   prod_mul;

  // Signed overflow: upper half must be a pure sign extension of the lower half.
  function automatic logic ovf_of(input logic [PW-1:0] p, input logic sgn);
    logic res;
    if (sgn) res = (p[PW-1:BITS] != {BITS{p[BITS-1]}});
    else     res = (p[PW-1:BITS] != '0);
    return res;
  endfunction

  assign req_ready = (state_q == IDLE) && mul_done;
  assign mul_en    = (state_q == ISSUE);
  assign mul_a     = mag_a_q;
  assign mul_b     = mag_b_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_hi    = prod_q[PW-1:BITS];
  assign rsp_lo    = prod_q[BITS-1:0];
  assign rsp_ovf   = ovf_q;

  // Negating the most-negative value wraps to 2^(BITS-1), which is the correct unsigned magnitude.
  always_comb begin
    abs_a    = (req_signed && req_a[BITS-1]) ? -req_a : req_a;
    abs_b    = (req_signed && req_b[BITS-1]) ? -req_b : req_b;
    accept   = req_valid && req_ready;
    req_zero = (req_a == '0) || (req_b == '0);
    prod_mul = neg_q ? -mul_result : mul_result;
  end

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    wd_d    = wd_q;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mag_a_d = abs_a;
          mag_b_d = abs_b;
          sgn_d   = req_signed;
          wd_d    = '0;
          if (req_zero) begin
            neg_d   = 1'b0;
            prod_d  = '0;
            ovf_d   = 1'b0;
            state_d = RESP;
          end else begin
            neg_d   = req_signed && (req_a[BITS-1] ^ req_b[BITS-1]);
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          prod_d  = prod_mul;
          ovf_d   = ovf_of(prod_mul, sgn_q);
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          // Multiplier never finished: report a saturated, flagged result instead of hanging.
          prod_d  = '1;
          ovf_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      wd_q    <= '0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      wd_q    <= wd_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 16, giving operand width; product width is 2*BITS.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  request offered.
REQ-005 req_ready  out  1  request accepted when req_valid && req_ready at posedge.
REQ-006 req_a, req_b  in  BITS each  operands.
REQ-007 req_signed  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 mul_en  out  1  start pulse to downstream shift-add multiplier.
REQ-009 mul_a, mul_b  out  BITS each  magnitudes presented to multiplier.
REQ-010 mul_result  in  2*BITS  unsigned product from multiplier.
REQ-011 mul_done  in  1  multiplier idle/result-valid indication (combinationally low while mul_en high).
REQ-012 rsp_valid  out  1  response held.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at posedge.
REQ-014 rsp_hi, rsp_lo  out  BITS each  upper/lower product halves.
REQ-015 rsp_ovf  out  1  product does not fit in BITS (unsigned: rsp_hi != 0; signed: rsp_hi != BITS copies of rsp_lo[BITS-1]).

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-017 req_ready SHALL equal (state == IDLE) && mul_done; no request accepted while multiplier busy.
REQ-018 On accept SHALL latch magnitudes |req_a|, |req_b| (abs only when req_signed) and neg = req_signed && (req_a[BITS-1] ^ req_b[BITS-1]).
REQ-019 Magnitude of most-negative value (1 followed by zeros) SHALL be 2^(BITS-1), representable in BITS unsigned bits.
REQ-020 Bypass: if req_a == 0 or req_b == 0 on accept, SHALL go IDLE->RESP with product 0, neg cleared, mul_en never asserted.
REQ-021 Otherwise IDLE->ISSUE; in ISSUE mul_en = 1 for exactly one cycle with mul_a/mul_b = latched magnitudes; ISSUE->WAIT unconditionally.
REQ-022 mul_a/mul_b SHALL stay stable from ISSUE through end of WAIT.
REQ-023 In WAIT mul_en = 0; on first posedge with mul_done = 1, SHALL capture product = neg ? -(mul_result) : mul_result (2*BITS two's complement) and go RESP.
REQ-024 Latency: rsp_valid SHALL rise BITS+2 cycles after accept edge for multiplied requests, 1 cycle after accept edge for bypass.
REQ-025 In RESP rsp_valid = 1, rsp_hi/rsp_lo/rsp_ovf held stable until rsp_ready; then RESP->IDLE.
REQ-026 Back-to-back: the cycle after response handshake SHALL be IDLE with req_ready = mul_done; no same-cycle accept in RESP.
REQ-027 Watchdog: SHALL count WAIT cycles; on count reaching 2*BITS+4 without mul_done, SHALL go RESP with rsp_hi = rsp_lo = all ones and rsp_ovf = 1.
REQ-028 req_* inputs SHALL be ignored outside the accept cycle.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, mul_en 0, rsp_valid 0, rsp_hi/rsp_lo/rsp_ovf 0, mul_a/mul_b 0, watchdog 0.
REQ-030 Reset mid-operation SHALL abort the request with no response; req_ready SHALL stay 0 after reset until mul_done = 1 (multiplier itself has no reset).

Verification (BITS = 16, real multiplier attached)
REQ-031 Unsigned 0x1234 * 0x5678 -> rsp_valid 18 cycles after accept, rsp_hi 0x0626, rsp_lo 0x0060, rsp_ovf 1.
REQ-032 Signed 0xFFFD (-3) * 0x0007 -> rsp_hi 0xFFFF, rsp_lo 0xFFEB, rsp_ovf 0; signed 0x8000 * 0x8000 -> rsp_hi 0x4000, rsp_lo 0x0000, rsp_ovf 1.
REQ-033 Bypass 0x0000 * 0xBEEF -> mul_en never high, rsp_valid 1 cycle after accept, product 0, rsp_ovf 0.
REQ-034 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, req_ready 0; rsp_ready 1 -> next cycle IDLE, req_ready 1.
REQ-035 rst_n pulsed low at cycle 5 of WAIT -> outputs zero asynchronously, no response, req_ready stays 0 until multiplier finishes, then next request 3*5 returns 15.
REQ-036 mul_done stubbed to 0 -> after 36 WAIT cycles response 0xFFFF/0xFFFF, rsp_ovf 1.
